// File: rtl/vga_tile_renderer.sv
// VGA tile renderer: mode timing, per-pixel tile fetch, colour map, syncs.
// Ports: clk, reset(async low), state_in/score in; re, raddr, R/G/B_out, HSync, VSync, frame_tick out. Option: VGA_SCORE_OVERLAY_EN.
module vga_tile_renderer #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int TILE_SHIFT = 4,
  parameter int GRID_COLS  = 40,
  parameter int GRID_ROWS  = 30,
  parameter int COLOR_W    = 4,
  parameter int ADDR_W     = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         state_in,
  input  logic [9:0]         score,
  output logic               re,
  output logic [ADDR_W-1:0]  raddr,
  output logic [COLOR_W-1:0] R_out,
  output logic [COLOR_W-1:0] G_out,
  output logic [COLOR_W-1:0] B_out,
  output logic               HSync,
  output logic               VSync,
  output logic               frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(CLK_DIV);
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;
  localparam logic [COLOR_W-1:0] C_ALL = '1;
  localparam logic [COLOR_W-1:0] C_DIM = COLOR_W'(1) << (COLOR_W - 1);

  logic [DW-1:0]      div_q, div_d;
  logic               pix_en;
  logic [HW-1:0]      hcnt_q, hcnt_d, dh_q;
  logic [VW-1:0]      vcnt_q, vcnt_d, dv_q;
  logic               re_q, re_d, fpend_q, fetched_q, vis_q;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;
  logic [3:0]         tile_q, src;
  logic [COLOR_W-1:0] r_q, g_q, b_q, r_d, g_d, b_d;
  logic               hs_q, vs_q, hs_d, vs_d, tick_q, tick_d;
  logic               in_grid, h_wrap, v_wrap, fetched;
  int                 hc, vc, dhc, dvc, addr_full;

  function automatic logic [COLOR_W-1:0] chan(input logic on, input logic dim);
    if (!on) return '0;
    return dim ? C_DIM : C_ALL;
  endfunction

  assign pix_en = (div_q == DW'(CLK_DIV - 1));

  // Counter advance and fetch request for the current pixel.
  always_comb begin
    div_d = pix_en ? '0 : div_q + DW'(1);
    hc = int'(hcnt_q);
    vc = int'(vcnt_q);
    h_wrap = (hc == H_TOTAL - 1);
    v_wrap = (vc == V_TOTAL - 1);
    in_grid = (hc < H_ACTIVE) && (vc < V_ACTIVE) &&
              ((hc >> TILE_SHIFT) < GRID_COLS) &&
              ((vc >> TILE_SHIFT) < GRID_ROWS);
    addr_full = (vc >> TILE_SHIFT) * GRID_COLS + (hc >> TILE_SHIFT);
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (pix_en) begin
      hcnt_d = h_wrap ? '0 : hcnt_q + HW'(1);
      if (h_wrap) vcnt_d = v_wrap ? '0 : vcnt_q + VW'(1);
    end
    tick_d = pix_en && h_wrap && (vc == V_ACTIVE - 1);
    re_d = pix_en && in_grid;
    raddr_d = re_d ? addr_full[ADDR_W-1:0] : raddr_q;
  end

`ifdef VGA_SCORE_OVERLAY_EN
  logic [9:0] score_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) score_q <= '0;
    else if (tick_d) score_q <= score;
  end
`else
  logic unused_score;
  assign unused_score = ^score;
`endif

  logic unused_hi;
  assign unused_hi = ^state_in[7:4];

  // Output stage for the pixel fetched one period earlier. With
  // CLK_DIV=2 the RAM data arrives on the same edge, hence the bypass.
  always_comb begin
    dhc = int'(dh_q);
    dvc = int'(dv_q);
    src = fpend_q ? state_in[3:0] : tile_q;
    fetched = fpend_q | fetched_q;
    r_d = chan(src[2], src[3]);
    g_d = chan(src[1], src[3]);
    b_d = chan(src[0], src[3]);
    if (!(vis_q && fetched)) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
`ifdef VGA_SCORE_OVERLAY_EN
    if (dvc < 8 && dhc < H_ACTIVE) begin
      r_d = (dhc < 4 * int'(score_q)) ? C_ALL : '0;
      g_d = r_d;
      b_d = r_d;
    end
`endif
    hs_d = !(dhc >= HS_BEG && dhc < HS_END);
    vs_d = !(dvc >= VS_BEG && dvc < VS_END);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      re_q      <= 1'b0;
      raddr_q   <= '0;
      fpend_q   <= 1'b0;
      fetched_q <= 1'b0;
      tile_q    <= '0;
      dh_q      <= '0;
      dv_q      <= '0;
      vis_q     <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      re_q    <= re_d;
      raddr_q <= raddr_d;
      fpend_q <= re_q;
      tick_q  <= tick_d;
      if (pix_en) begin
        r_q       <= r_d;
        g_q       <= g_d;
        b_q       <= b_d;
        hs_q      <= hs_d;
        vs_q      <= vs_d;
        dh_q      <= hcnt_q;
        dv_q      <= vcnt_q;
        vis_q     <= in_grid;
        fetched_q <= 1'b0;
      end else if (fpend_q) begin
        tile_q    <= state_in[3:0];
        fetched_q <= 1'b1;
      end
    end
  end

  assign re         = re_q;
  assign raddr      = raddr_q;
  assign R_out      = r_q;
  assign G_out      = g_q;
  assign B_out      = b_q;
  assign HSync      = hs_q;
  assign VSync      = vs_q;
  assign frame_tick = tick_q;

endmodule
